// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: owns IME and EI/DI/RETI, selects the highest-priority pending
// source at instruction boundaries and sequences the 5-M-cycle push/jump dispatch.
module interrupt_dispatcher #(
   parameter int unsigned NUM_SOURCES   = 5,
   parameter logic [15:0] VECTOR_BASE   = 16'h0040,
   parameter int unsigned VECTOR_STRIDE = 8
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [7:0]  iInterruptFlag,
   input  logic [7:0]  iInterruptEnable,
   input  logic        iMcycleStrobe,
   input  logic        iInstructionBoundary,
   input  logic        iEi,
   input  logic        iDi,
   input  logic        iReti,
   output logic        oIme,
   output logic        oStallFetch,
   output logic        oPushHigh,
   output logic        oPushLow,
   output logic        oPcLoad,
   output logic [15:0] oVector,
   output logic [7:0]  oAck,
   output logic        oHaltWake
);

   localparam int unsigned IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT0,
      S_WAIT1,
      S_PUSH_HI,
      S_PUSH_LO,
      S_JUMP
   } state_t;

   state_t           state_q, state_d;
   logic             ime_q, ime_d;
   logic             ei_pending_q, ei_pending_d;
   logic             halt_wake_q, halt_wake_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      vector_q, vector_d;
   logic [7:0]       ack_q, ack_d;

   logic [NUM_SOURCES-1:0] pending;
   logic [IDX_W-1:0]       win_idx;
   logic [15:0]            win_vector;
   logic                   unused_upper_bits;

   assign pending           = iInterruptFlag[NUM_SOURCES-1:0] & iInterruptEnable[NUM_SOURCES-1:0];
   assign unused_upper_bits = ^{iInterruptFlag, iInterruptEnable};

   // Scanning downwards lets the lowest set bit overwrite, so bit 0 has top priority.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (pending[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   assign win_vector = VECTOR_BASE + 16'(VECTOR_STRIDE) * 16'(win_idx);

   always_comb begin
      state_d      = state_q;
      ime_d        = ime_q;
      ei_pending_d = ei_pending_q;
      idx_d        = idx_q;
      vector_d     = vector_q;
      ack_d        = '0;
      halt_wake_d  = |pending;

      case (state_q)
         S_IDLE: begin
            if (iInstructionBoundary) begin
               if ((ime_q || ei_pending_q) && (|pending) && !iEi && !iDi) begin
                  state_d      = S_WAIT0;
                  idx_d        = win_idx;
                  vector_d     = win_vector;
                  ime_d        = 1'b0;
                  ei_pending_d = 1'b0;
               end else if (iDi) begin
                  ime_d        = 1'b0;
                  ei_pending_d = 1'b0;
               end else if (iEi) begin
                  // A back-to-back EI still lets the earlier one take effect.
                  if (ei_pending_q) begin
                     ime_d = 1'b1;
                  end
                  ei_pending_d = 1'b1;
               end else if (iReti || ei_pending_q) begin
                  ime_d        = 1'b1;
                  ei_pending_d = 1'b0;
               end
            end
         end
         S_WAIT0:   if (iMcycleStrobe) state_d = S_WAIT1;
         S_WAIT1:   if (iMcycleStrobe) state_d = S_PUSH_HI;
         S_PUSH_HI: if (iMcycleStrobe) state_d = S_PUSH_LO;
         S_PUSH_LO: begin
            if (iMcycleStrobe) begin
               state_d      = S_JUMP;
               ack_d[idx_q] = 1'b1;
            end
         end
         S_JUMP:    if (iMcycleStrobe) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q      <= S_IDLE;
         ime_q        <= 1'b0;
         ei_pending_q <= 1'b0;
         halt_wake_q  <= 1'b0;
         idx_q        <= '0;
         vector_q     <= 16'h0000;
         ack_q        <= 8'h00;
      end else begin
         state_q      <= state_d;
         ime_q        <= ime_d;
         ei_pending_q <= ei_pending_d;
         halt_wake_q  <= halt_wake_d;
         idx_q        <= idx_d;
         vector_q     <= vector_d;
         ack_q        <= ack_d;
      end
   end

   assign oIme        = ime_q;
   assign oStallFetch = (state_q != S_IDLE);
   assign oPushHigh   = (state_q == S_PUSH_HI);
   assign oPushLow    = (state_q == S_PUSH_LO);
   assign oPcLoad     = (state_q == S_JUMP) && iMcycleStrobe;
   assign oVector     = (state_q != S_IDLE) ? vector_q : 16'h0000;
   assign oAck        = ack_q;
   assign oHaltWake   = halt_wake_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed scenarios plus randomized traffic, checked each clock against a
// reference model of the dispatcher expressed as an M-cycle count into the dispatch.
module tb_interrupt_dispatcher;

   logic        iClock = 1'b0;
   logic        iReset = 1'b0;
   logic [7:0]  iInterruptFlag = 8'h00;
   logic [7:0]  iInterruptEnable = 8'h00;
   logic        iMcycleStrobe = 1'b0;
   logic        iInstructionBoundary = 1'b0;
   logic        iEi = 1'b0;
   logic        iDi = 1'b0;
   logic        iReti = 1'b0;
   logic        oIme, oStallFetch, oPushHigh, oPushLow, oPcLoad, oHaltWake;
   logic [15:0] oVector;
   logic [7:0]  oAck;

   interrupt_dispatcher dut (
      .iClock               (iClock),
      .iReset               (iReset),
      .iInterruptFlag       (iInterruptFlag),
      .iInterruptEnable     (iInterruptEnable),
      .iMcycleStrobe        (iMcycleStrobe),
      .iInstructionBoundary (iInstructionBoundary),
      .iEi                  (iEi),
      .iDi                  (iDi),
      .iReti                (iReti),
      .oIme                 (oIme),
      .oStallFetch          (oStallFetch),
      .oPushHigh            (oPushHigh),
      .oPushLow             (oPushLow),
      .oPcLoad              (oPcLoad),
      .oVector              (oVector),
      .oAck                 (oAck),
      .oHaltWake            (oHaltWake)
   );

   always #5 iClock = ~iClock;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: m_mcyc = -1 when idle, else M-cycle number 0..4 within the dispatch.
   int          m_mcyc = -1;
   int          m_idx  = 0;
   logic        m_ime  = 1'b0;
   logic        m_eip  = 1'b0;
   logic        m_hw   = 1'b0;
   logic [7:0]  m_ack  = 8'h00;
   logic [15:0] m_vec  = 16'h0000;

   logic r_bnd, r_ei, r_di, r_reti;
   int   r_sel;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("stall",    16'(oStallFetch), 16'(m_mcyc >= 0));
      chk("push_hi",  16'(oPushHigh),   16'(m_mcyc == 2));
      chk("push_lo",  16'(oPushLow),    16'(m_mcyc == 3));
      chk("pc_load",  16'(oPcLoad),     16'((m_mcyc == 4) && iMcycleStrobe));
      chk("vector",   oVector,          (m_mcyc >= 0) ? m_vec : 16'h0000);
      chk("ack",      16'(oAck),        16'(m_ack));
      chk("ime",      16'(oIme),        16'(m_ime));
      chk("halt_wake",16'(oHaltWake),   16'(m_hw));
   endtask

   task automatic model_step();
      logic [4:0] p;
      logic [7:0] next_ack;
      int         idx;
      p        = iInterruptFlag[4:0] & iInterruptEnable[4:0];
      next_ack = 8'h00;
      if (m_mcyc < 0) begin
         if (iInstructionBoundary) begin
            if ((m_ime || m_eip) && p != 5'd0 && !iEi && !iDi) begin
               idx = 0;
               while (!p[idx]) idx++;
               m_idx  = idx;
               m_vec  = 16'h0040 + 16'(8 * idx);
               m_mcyc = 0;
               m_ime  = 1'b0;
               m_eip  = 1'b0;
            end else if (iDi) begin
               m_ime = 1'b0;
               m_eip = 1'b0;
            end else if (iEi) begin
               if (m_eip) m_ime = 1'b1;
               m_eip = 1'b1;
            end else begin
               if (iReti || m_eip) m_ime = 1'b1;
               m_eip = 1'b0;
            end
         end
      end else if (iMcycleStrobe) begin
         if (m_mcyc == 3) next_ack = 8'(1 << m_idx);
         m_mcyc = (m_mcyc == 4) ? -1 : m_mcyc + 1;
      end
      m_ack = next_ack;
      m_hw  = (p != 5'd0);
   endtask

   task automatic drive(input logic stb, input logic bnd, input logic ei, input logic di, input logic reti);
      iMcycleStrobe        = stb;
      iInstructionBoundary = bnd;
      iEi                  = ei;
      iDi                  = di;
      iReti                = reti;
      #1;
      check_model();
   endtask

   task automatic adv();
      model_step();
      @(posedge iClock);
      #1;
   endtask

   task automatic step(input logic stb, input logic bnd, input logic ei, input logic di, input logic reti);
      drive(stb, bnd, ei, di, reti);
      adv();
   endtask

   task automatic mc(input logic bnd, input logic ei, input logic di, input logic reti, input int gaps);
      step(1'b1, bnd, ei, di, reti);
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      iReset = 1'b1;
      #1;
      m_mcyc = -1; m_ime = 1'b0; m_eip = 1'b0; m_hw = 1'b0; m_ack = 8'h00; m_vec = 16'h0000;
      chk("rst_stall",   16'(oStallFetch), 16'h0000);
      chk("rst_push_hi", 16'(oPushHigh),   16'h0000);
      chk("rst_pc_load", 16'(oPcLoad),     16'h0000);
      chk("rst_ack",     16'(oAck),        16'h0000);
      chk("rst_ime",     16'(oIme),        16'h0000);
      chk("rst_vector",  oVector,          16'h0000);
      chk("rst_hw",      16'(oHaltWake),   16'h0000);
      @(posedge iClock);
      #1;
      iReset = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();

      // IME=1, IF=0x14 IE=0x1F: source 2 wins, vector 0x0050, ack 0x04.
      mc(1, 0, 0, 1, 1);
      chk("reti_ime", 16'(oIme), 16'h0001);
      iInterruptFlag = 8'h14; iInterruptEnable = 8'h1F;
      mc(1, 0, 0, 0, 1);
      chk("t2_stall", 16'(oStallFetch), 16'h0001);
      chk("t2_vec_w0", oVector, 16'h0050);
      chk("t2_ime_cleared", 16'(oIme), 16'h0000);
      mc(0, 0, 0, 0, 1);
      mc(0, 0, 0, 0, 1);
      chk("t2_push_hi", 16'(oPushHigh), 16'h0001);
      mc(0, 0, 0, 0, 1);
      chk("t2_push_lo", 16'(oPushLow), 16'h0001);
      step(1, 0, 0, 0, 0);
      chk("t2_ack", 16'(oAck), 16'h0004);
      drive(1, 0, 0, 0, 0);
      chk("t2_pc_load", 16'(oPcLoad), 16'h0001);
      chk("t2_pc_vec", oVector, 16'h0050);
      adv();
      chk("t2_done_stall", 16'(oStallFetch), 16'h0000);
      chk("t2_done_ime", 16'(oIme), 16'h0000);

      // IME=0 with a pending source: only the halt wake-up reacts.
      iInterruptFlag = 8'h00; iInterruptEnable = 8'h00;
      step(0, 0, 0, 0, 0);
      iInterruptFlag = 8'h01; iInterruptEnable = 8'h01;
      drive(0, 0, 0, 0, 0);
      chk("t3_hw_before", 16'(oHaltWake), 16'h0000);
      adv();
      chk("t3_hw_after", 16'(oHaltWake), 16'h0001);
      mc(1, 0, 0, 0, 1);
      mc(1, 0, 0, 0, 1);
      chk("t3_no_dispatch", 16'(oStallFetch), 16'h0000);

      // EI delays IME by one instruction.
      mc(1, 1, 0, 0, 1);
      chk("t4_no_dispatch_at_ei", 16'(oStallFetch), 16'h0000);
      mc(1, 0, 0, 0, 0);
      chk("t4_dispatch_next", 16'(oStallFetch), 16'h0001);
      chk("t4_vector", oVector, 16'h0040);
      repeat (5) mc(0, 0, 0, 0, 1);

      // EI then DI cancels the pending enable.
      mc(1, 1, 0, 0, 1);
      mc(1, 0, 1, 0, 1);
      chk("t5_di_stall", 16'(oStallFetch), 16'h0000);
      chk("t5_di_ime", 16'(oIme), 16'h0000);
      mc(1, 0, 0, 0, 1);
      chk("t5_later_stall", 16'(oStallFetch), 16'h0000);

      // RETI enables immediately; dispatch on the following boundary.
      iInterruptFlag = 8'h02; iInterruptEnable = 8'h02;
      mc(1, 0, 0, 1, 1);
      chk("t5_reti_ime", 16'(oIme), 16'h0001);
      chk("t5_reti_stall", 16'(oStallFetch), 16'h0000);
      mc(1, 0, 0, 0, 1);
      chk("t5_reti_vector", oVector, 16'h0048);
      repeat (5) mc(0, 0, 0, 0, 1);

      // Source changes mid-dispatch do not alter the latched target.
      iInterruptFlag = 8'h00;
      mc(1, 0, 0, 1, 1);
      iInterruptFlag = 8'h08; iInterruptEnable = 8'h08;
      mc(1, 0, 0, 0, 1);
      chk("t6_vector_start", oVector, 16'h0058);
      mc(0, 0, 0, 0, 0);
      iInterruptFlag = 8'h01;
      step(0, 0, 0, 0, 0);
      mc(0, 0, 0, 0, 1);
      mc(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("t6_ack", 16'(oAck), 16'h0008);
      drive(1, 0, 0, 0, 0);
      chk("t6_pc_load", 16'(oPcLoad), 16'h0001);
      chk("t6_pc_vec", oVector, 16'h0058);
      adv();

      // Reset in the middle of PUSH_HI aborts the dispatch.
      iInterruptFlag = 8'h01; iInterruptEnable = 8'h01;
      mc(1, 0, 0, 1, 1);
      mc(1, 0, 0, 0, 1);
      mc(0, 0, 0, 0, 1);
      mc(0, 0, 0, 0, 1);
      chk("t1_in_push_hi", 16'(oPushHigh), 16'h0001);
      do_reset();
      repeat (4) mc(1, 0, 0, 0, 1);
      chk("t1_post_reset_stall", 16'(oStallFetch), 16'h0000);

      // Randomized traffic, including boundaries and IF/IE changes during dispatch.
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            iInterruptFlag   = 8'($urandom);
            iInterruptEnable = 8'($urandom);
            if ($urandom_range(0, 2) == 0) iInterruptEnable = iInterruptEnable & 8'hE0;
         end
         r_bnd  = ($urandom_range(0, 2) != 0);
         r_sel  = int'($urandom_range(0, 9));
         r_ei   = r_bnd && (r_sel <= 1);
         r_di   = r_bnd && (r_sel == 2);
         r_reti = r_bnd && (r_sel == 3 || r_sel == 4);
         mc(r_bnd, r_ei, r_di, r_reti, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
